// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the execute-stage sequencer: opcodes, condition
// codes, NZCV bit positions, FSM encoding and opcode-class helpers.
package alu_exec_ctrl_pkg;

   // Data-processing opcodes
   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Bit positions inside the {N,Z,C,V} nibble
   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COND = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   // Compare/test opcodes: never write back, always update flags
   function automatic logic is_cmp_op(input logic [3:0] op);
      return (op[3:2] == 2'b10);
   endfunction

   // Opcodes whose C and V come from the adder
   function automatic logic is_arith_op(input logic [3:0] op);
      return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Bundle of request, ALU, write-back, flag and statistics signals around
// the execute-stage sequencer.
//
// Request handshake: a request transfers on a rising clk edge where both
// req_valid and req_ready are high. req_ready is high only while the
// sequencer is idle; the request fields are captured on that edge and need
// not be held afterwards. The requester may raise req_valid at any time and
// must keep the fields stable while req_valid is high and req_ready is low.
interface alu_exec_ctrl_if
   import alu_exec_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_cond;
   logic [3:0]        req_op;
   logic              req_s;
   logic [3:0]        req_rd;
   logic [DATA_W-1:0] req_rn;
   logic [DATA_W-1:0] req_op2;

   logic [DATA_W-1:0] alu_src1;
   logic [DATA_W-1:0] alu_src2;
   logic [3:0]        alu_op;
   logic              alu_c_in;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_nzcv;

   logic              wb_valid;
   logic [3:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;

   logic              flag_load;
   logic [3:0]        flag_load_data;
   logic [3:0]        flags;

   logic [CNT_W-1:0]  exec_cnt;
   logic [CNT_W-1:0]  skip_cnt;

   state_t            dbg_state;

   // Sequencer side
   modport slave (
      input  req_valid, req_cond, req_op, req_s, req_rd, req_rn, req_op2,
      input  alu_result, alu_nzcv, flag_load, flag_load_data,
      output req_ready, alu_src1, alu_src2, alu_op, alu_c_in,
      output wb_valid, wb_rd, wb_data, flags, exec_cnt, skip_cnt, dbg_state
   );

   // Decode / ALU / register-file side
   modport master (
      output req_valid, req_cond, req_op, req_s, req_rd, req_rn, req_op2,
      output alu_result, alu_nzcv, flag_load, flag_load_data,
      input  req_ready, alu_src1, alu_src2, alu_op, alu_c_in,
      input  wb_valid, wb_rd, wb_data, flags, exec_cnt, skip_cnt, dbg_state
   );

endinterface

// File: rtl/alu_exec_ctrl_cond_check.sv
// Condition-code evaluator: decides whether an instruction with the given
// 4-bit condition executes under the given NZCV flags. Purely combinational.
module alu_exec_ctrl_cond_check
   import alu_exec_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[N_BIT];
   assign z = nzcv[Z_BIT];
   assign c = nzcv[C_BIT];
   assign v = nzcv[V_BIT];

   // Condition table lookup
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts a data-processing request, checks its
// condition against the NZCV register, drives the external ALU for one
// cycle, then issues a one-cycle write-back and updates flags. Also keeps
// saturating executed/skipped instruction counters.
module alu_exec_ctrl
   import alu_exec_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
)(
   input  logic          clk,
   input  logic          rst,
   alu_exec_ctrl_if.slave bus
);

   state_t            state_q, state_d;

   logic [3:0]        cond_q, op_q, rd_q;
   logic              s_q;
   logic [DATA_W-1:0] rn_q, op2_q;

   logic [DATA_W-1:0] result_q;
   logic [3:0]        nzcv_q;
   logic [DATA_W-1:0] src1_hold, src2_hold;

   logic [3:0]        flags_q;
   logic [CNT_W-1:0]  exec_q, skip_q;

   logic              cond_pass;
   logic              accept;
   logic              capture;
   logic              exec_inc;
   logic              skip_inc;
   logic              ready;
   logic              wb_strobe;
   logic [3:0]        alu_op_d;
   logic              flag_wr;

   alu_exec_ctrl_cond_check u_cond_check (
      .cond (cond_q),
      .nzcv (flags_q),
      .pass (cond_pass)
   );

   assign accept  = (state_q == IDLE) && bus.req_valid;
   assign flag_wr = (state_q == WB) && (s_q || is_cmp_op(op_q));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and per-state control strobes
   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      wb_strobe = 1'b0;
      alu_op_d  = OP_AND;
      capture   = 1'b0;
      exec_inc  = 1'b0;
      skip_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (bus.req_valid) state_d = COND;
         end
         COND: begin
            if (cond_pass) begin
               state_d = EXEC;
            end else begin
               skip_inc = 1'b1;
               state_d  = IDLE;
            end
         end
         EXEC: begin
            alu_op_d = op_q;
            capture  = 1'b1;
            state_d  = WB;
         end
         WB: begin
            wb_strobe = !is_cmp_op(op_q);
            exec_inc  = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture on the handshake edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cond_q <= '0;
         op_q   <= '0;
         s_q    <= 1'b0;
         rd_q   <= '0;
         rn_q   <= '0;
         op2_q  <= '0;
      end else if (accept) begin
         cond_q <= bus.req_cond;
         op_q   <= bus.req_op;
         s_q    <= bus.req_s;
         rd_q   <= bus.req_rd;
         rn_q   <= bus.req_rn;
         op2_q  <= bus.req_op2;
      end
   end

   // ALU result capture at the end of EXEC; operands are held afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q  <= '0;
         nzcv_q    <= '0;
         src1_hold <= '0;
         src2_hold <= '0;
      end else if (capture) begin
         result_q  <= bus.alu_result;
         nzcv_q    <= bus.alu_nzcv;
         src1_hold <= rn_q;
         src2_hold <= op2_q;
      end
   end

   // NZCV register: external load has priority over write-back update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
      end else if (bus.flag_load) begin
         flags_q <= bus.flag_load_data;
      end else if (flag_wr) begin
         if (is_arith_op(op_q)) flags_q <= nzcv_q;
         else                   flags_q <= {nzcv_q[N_BIT], nzcv_q[Z_BIT], flags_q[C_BIT], flags_q[V_BIT]};
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exec_q <= '0;
         skip_q <= '0;
      end else begin
         if (exec_inc && (exec_q != {CNT_W{1'b1}})) exec_q <= exec_q + 1'b1;
         if (skip_inc && (skip_q != {CNT_W{1'b1}})) skip_q <= skip_q + 1'b1;
      end
   end

   assign bus.req_ready = ready;
   assign bus.alu_src1  = (state_q == EXEC) ? rn_q  : src1_hold;
   assign bus.alu_src2  = (state_q == EXEC) ? op2_q : src2_hold;
   assign bus.alu_op    = alu_op_d;
   assign bus.alu_c_in  = flags_q[C_BIT];
   assign bus.wb_valid  = wb_strobe;
   assign bus.wb_rd     = rd_q;
   assign bus.wb_data   = result_q;
   assign bus.flags     = flags_q;
   assign bus.exec_cnt  = exec_q;
   assign bus.skip_cnt  = skip_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for the execute-stage sequencer. A small behavioural ALU
// answers the sequencer's ALU port; expected values are hand-computed.
module tb_alu_exec_ctrl;
   import alu_exec_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   alu_exec_ctrl_if #(.DATA_W(32), .CNT_W(16)) bus ();

   alu_exec_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU
   logic [31:0] ax, ay, ar;
   logic        aci, add_en, ac, av;
   logic [32:0] asum;
   always_comb begin
      ax     = bus.alu_src1;
      ay     = bus.alu_src2;
      aci    = 1'b0;
      add_en = 1'b1;
      case (bus.alu_op)
         OP_SUB, OP_CMP: begin ay = ~bus.alu_src2; aci = 1'b1; end
         OP_RSB:         begin ax = bus.alu_src2; ay = ~bus.alu_src1; aci = 1'b1; end
         OP_ADD, OP_CMN: aci = 1'b0;
         OP_ADC:         aci = bus.alu_c_in;
         OP_SBC:         begin ay = ~bus.alu_src2; aci = bus.alu_c_in; end
         OP_RSC:         begin ax = bus.alu_src2; ay = ~bus.alu_src1; aci = bus.alu_c_in; end
         default:        add_en = 1'b0;
      endcase
      asum = {1'b0, ax} + {1'b0, ay} + {32'd0, aci};
      case (bus.alu_op)
         OP_AND, OP_TST: ar = bus.alu_src1 & bus.alu_src2;
         OP_EOR, OP_TEQ: ar = bus.alu_src1 ^ bus.alu_src2;
         OP_ORR:         ar = bus.alu_src1 | bus.alu_src2;
         OP_MOV:         ar = bus.alu_src2;
         OP_BIC:         ar = bus.alu_src1 & ~bus.alu_src2;
         OP_MVN:         ar = ~bus.alu_src2;
         default:        ar = asum[31:0];
      endcase
      ac = add_en ? asum[32] : bus.alu_c_in;
      av = add_en ? ((ax[31] == ay[31]) && (asum[31] != ax[31])) : 1'b0;
      bus.alu_result = ar;
      bus.alu_nzcv   = {ar[31], (ar == 32'd0), ac, av};
   end

   // Observation results of the last instruction
   int          wb_n, wb_c, rdy_c;
   logic [3:0]  w_rd;
   logic [31:0] w_data;
   logic        w_cin;

   // Condition table: flags, cond, expected execute
   localparam logic [3:0] TF [10] = '{4'b0000, 4'b0010, 4'b0110, 4'b1000, 4'b1001,
                                      4'b1001, 4'b0100, 4'b0000, 4'b0000, 4'b0001};
   localparam logic [3:0] TC [10] = '{COND_HI, COND_HI, COND_LS, COND_GE, COND_GE,
                                      COND_GT, COND_LE, COND_NV, COND_CC, COND_VC};
   localparam logic       TE [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                      1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   task automatic send(input logic [3:0] c, input logic [3:0] op, input logic s,
                       input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] op2);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         checks++;
         errors++;
         $display("FAIL send_ready: got %0b expected 1", bus.req_ready);
      end
      bus.req_valid = 1'b1;
      bus.req_cond  = c;
      bus.req_op    = op;
      bus.req_s     = s;
      bus.req_rd    = rd;
      bus.req_rn    = rn;
      bus.req_op2   = op2;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   // Observe cycles 1..4 after the acceptance edge
   task automatic watch(output int wn, output int wc, output int rc,
                        output logic [3:0] rd_o, output logic [31:0] data_o, output logic cin_o);
      wn = 0; wc = -1; rc = -1; rd_o = '0; data_o = '0; cin_o = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (bus.dbg_state == EXEC) cin_o = bus.alu_c_in;
         if (bus.wb_valid) begin
            wn++;
            wc     = i;
            rd_o   = bus.wb_rd;
            data_o = bus.wb_data;
         end
         if (bus.req_ready && rc < 0) rc = i;
      end
   endtask

   task automatic load_flags(input logic [3:0] d);
      @(negedge clk);
      bus.flag_load      = 1'b1;
      bus.flag_load_data = d;
      @(posedge clk);
      #1 bus.flag_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
      checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", bus.flags); end
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
      checks++; if (bus.exec_cnt !== 16'd0 || bus.skip_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.exec_cnt, bus.skip_cnt); end
      checks++; if (bus.dbg_state !== IDLE || bus.wb_data !== 32'd0) begin errors++; $display("FAIL reset_state: got %0d/%h expected 0/0", bus.dbg_state, bus.wb_data); end
   endtask

   task automatic test_add_overflow();
      send(COND_AL, OP_ADD, 1'b1, 4'd7, 32'h7FFF_FFFF, 32'h0000_0001);
      watch(wb_n, wb_c, rdy_c, w_rd, w_data, w_cin);
      checks++; if (wb_n !== 1 || wb_c !== 3) begin errors++; $display("FAIL add_wb_timing: got count %0d cycle %0d expected 1 at 3", wb_n, wb_c); end
      checks++; if (w_data !== 32'h8000_0000 || w_rd !== 4'd7) begin errors++; $display("FAIL add_wb_data: got rd %0d data %h expected 7 80000000", w_rd, w_data); end
      checks++; if (bus.flags !== 4'b1001) begin errors++; $display("FAIL add_flags: got %b expected 1001", bus.flags); end
      checks++; if (rdy_c !== 4) begin errors++; $display("FAIL add_ready_cycle: got %0d expected 4", rdy_c); end
      checks++; if (bus.exec_cnt !== 16'd1) begin errors++; $display("FAIL add_exec_cnt: got %0d expected 1", bus.exec_cnt); end
   endtask

   task automatic test_cmp_sequence();
      send(COND_AL, OP_CMP, 1'b0, 4'd9, 32'd5, 32'd5);
      watch(wb_n, wb_c, rdy_c, w_rd, w_data, w_cin);
      checks++; if (wb_n !== 0) begin errors++; $display("FAIL cmp_no_wb: got %0d strobes expected 0", wb_n); end
      checks++; if (bus.flags !== 4'b0110) begin errors++; $display("FAIL cmp_flags: got %b expected 0110", bus.flags); end
      send(COND_EQ, OP_MOV, 1'b0, 4'd3, 32'd0, 32'h0000_1234);
      watch(wb_n, wb_c, rdy_c, w_rd, w_data, w_cin);
      checks++; if (wb_n !== 1 || w_rd !== 4'd3 || w_data !== 32'h0000_1234) begin errors++; $display("FAIL mov_eq_wb: got n %0d rd %0d data %h expected 1 3 00001234", wb_n, w_rd, w_data); end
      send(COND_NE, OP_MOV, 1'b1, 4'd4, 32'd0, 32'h0000_5678);
      watch(wb_n, wb_c, rdy_c, w_rd, w_data, w_cin);
      checks++; if (wb_n !== 0) begin errors++; $display("FAIL mov_ne_skip: got %0d strobes expected 0", wb_n); end
      checks++; if (bus.skip_cnt !== 16'd1) begin errors++; $display("FAIL mov_ne_skip_cnt: got %0d expected 1", bus.skip_cnt); end
      checks++; if (bus.flags !== 4'b0110) begin errors++; $display("FAIL mov_ne_flags: got %b expected 0110", bus.flags); end
      checks++; if (rdy_c !== 2) begin errors++; $display("FAIL skip_ready_cycle: got %0d expected 2", rdy_c); end
   endtask

   task automatic test_adc_carry();
      load_flags(4'b0011);
      send(COND_AL, OP_ADC, 1'b0, 4'd2, 32'd1, 32'd2);
      watch(wb_n, wb_c, rdy_c, w_rd, w_data, w_cin);
      checks++; if (w_cin !== 1'b1) begin errors++; $display("FAIL adc_c_in: got %b expected 1", w_cin); end
      checks++; if (wb_n !== 1 || w_data !== 32'd4) begin errors++; $display("FAIL adc_wb_data: got n %0d data %h expected 1 00000004", wb_n, w_data); end
      checks++; if (bus.flags !== 4'b0011) begin errors++; $display("FAIL adc_flags: got %b expected 0011", bus.flags); end
      checks++; if (bus.exec_cnt !== 16'd4) begin errors++; $display("FAIL adc_exec_cnt: got %0d expected 4", bus.exec_cnt); end
   endtask

   task automatic test_cond_table();
      logic [31:0] v;
      for (int i = 0; i < 10; i++) begin
         load_flags(TF[i]);
         v = $urandom;
         send(TC[i], OP_MOV, 1'b0, 4'd1, 32'd0, v);
         watch(wb_n, wb_c, rdy_c, w_rd, w_data, w_cin);
         checks++; if (wb_n !== (TE[i] ? 1 : 0)) begin errors++; $display("FAIL cond_row%0d: got %0d strobes expected %0d", i, wb_n, TE[i]); end
         checks++; if (TE[i] && w_data !== v) begin errors++; $display("FAIL cond_row%0d_data: got %h expected %h", i, w_data, v); end
         checks++; if (bus.flags !== TF[i]) begin errors++; $display("FAIL cond_row%0d_flags: got %b expected %b", i, bus.flags, TF[i]); end
      end
      checks++; if (bus.exec_cnt !== 16'd10 || bus.skip_cnt !== 16'd5) begin errors++; $display("FAIL cond_counts: got %0d/%0d expected 10/5", bus.exec_cnt, bus.skip_cnt); end
   endtask

   task automatic test_logical_flags();
      load_flags(4'b0011);
      send(COND_AL, OP_AND, 1'b1, 4'd5, 32'h0000_00F0, 32'h0000_000F);
      watch(wb_n, wb_c, rdy_c, w_rd, w_data, w_cin);
      checks++; if (wb_n !== 1 || w_data !== 32'd0) begin errors++; $display("FAIL and_wb_data: got n %0d data %h expected 1 00000000", wb_n, w_data); end
      checks++; if (bus.flags !== 4'b0111) begin errors++; $display("FAIL and_flags: got %b expected 0111", bus.flags); end
      // Same instruction again with an external load landing on the WB edge
      send(COND_AL, OP_AND, 1'b1, 4'd5, 32'h0000_00F0, 32'h0000_000F);
      repeat (3) @(negedge clk);
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL and2_wb_cycle: got %b expected 1", bus.wb_valid); end
      bus.flag_load      = 1'b1;
      bus.flag_load_data = 4'b1000;
      @(posedge clk);
      #1 bus.flag_load = 1'b0;
      @(negedge clk);
      checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL load_priority: got %b expected 1000", bus.flags); end
   endtask

   task automatic test_reset_mid_exec();
      int seen;
      seen = 0;
      send(COND_AL, OP_ADD, 1'b1, 4'd6, 32'd1, 32'd1);
      repeat (2) @(negedge clk);
      checks++; if (bus.dbg_state !== EXEC) begin errors++; $display("FAIL rst_mid_in_exec: got %0d expected %0d", bus.dbg_state, EXEC); end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (bus.wb_valid) seen++;
      end
      rst = 1'b0;
      @(negedge clk);
      if (bus.wb_valid) seen++;
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_wb: got %0d strobes expected 0", seen); end
      checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000", bus.flags); end
      checks++; if (bus.dbg_state !== IDLE || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got state %0d ready %b expected 0 1", bus.dbg_state, bus.req_ready); end
      checks++; if (bus.exec_cnt !== 16'd0 || bus.skip_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_counters: got %0d/%0d expected 0/0", bus.exec_cnt, bus.skip_cnt); end
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      rst                = 1'b1;
      bus.req_valid      = 1'b0;
      bus.req_cond       = '0;
      bus.req_op         = '0;
      bus.req_s          = 1'b0;
      bus.req_rd         = '0;
      bus.req_rn         = '0;
      bus.req_op2        = '0;
      bus.flag_load      = 1'b0;
      bus.flag_load_data = '0;

      test_reset();
      test_add_overflow();
      test_cmp_sequence();
      test_adc_carry();
      test_cond_table();
      test_logical_flags();
      test_reset_mid_exec();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
